// File: rtl/race_turn_controller.sv
// race_turn_controller: turn-based dice race driven by the dice color detector.
// Each accepted roll moves the current player one square per STEP_DELAY cycles.
// The player who lands exactly on TRACK_LEN wins.
// The FSM state is exported on game_state. Overlay logic and checkers observe it there.
//
// Handshake: the detector has no ready signal. result_ready is a one-cycle valid
// strobe qualifying stable_color in the same cycle. A roll is accepted only in
// WAIT_ROLL with a non-NONE color; in every other state the strobe is dropped.
module race_turn_controller #(
  parameter int NUM_PLAYERS = 2,
  parameter int TRACK_LEN   = 20,
  parameter int RED_STEPS   = 1,
  parameter int GREEN_STEPS = 2,
  parameter int BLUE_STEPS  = 3,
  parameter int STEP_DELAY  = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  stable_color,
  input  logic        result_ready,
  input  logic        current_state_white,
  input  logic        start,
  output logic [2:0]  game_state,
  output logic [1:0]  cur_player,
  output logic [19:0] positions,
  output logic [1:0]  steps_left,
  output logic [1:0]  last_color,
  output logic        step_pulse,
  output logic        turn_done,
  output logic        winner_valid,
  output logic [1:0]  winner
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_WHITE = 3'd1,
    S_WAIT_ROLL  = 3'd2,
    S_MOVE       = 3'd3,
    S_NEXT       = 3'd4,
    S_WIN        = 3'd5
  } state_t;

  // The timer only has to hold STEP_DELAY-1.
  localparam int            TW      = (STEP_DELAY > 1) ? $clog2(STEP_DELAY) : 1;
  localparam logic [TW-1:0] RELOAD  = TW'(STEP_DELAY - 1);
  localparam logic [4:0]    FINISH  = 5'(TRACK_LEN);
  localparam logic [1:0]    LAST_PL = 2'(NUM_PLAYERS - 1);
  localparam logic [1:0]    RED_N   = 2'(RED_STEPS);
  localparam logic [1:0]    GREEN_N = 2'(GREEN_STEPS);
  localparam logic [1:0]    BLUE_N  = 2'(BLUE_STEPS);

  state_t        state_q, state_d;
  logic [1:0]    cur_q, cur_d;
  logic [4:0]    pos_q [4];
  logic [4:0]    pos_d [4];
  logic [1:0]    steps_q, steps_d;
  logic [1:0]    color_q, color_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    winner_q, winner_d;
  logic          pulse_q, pulse_d;
  logic          done_q, done_d;
  logic          win_q, win_d;
  logic [4:0]    pos_inc;

  // Next-state and next-value logic. start overrides every other event.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pos_d   = pos_q;
    steps_d = steps_q;
    color_d = color_q;
    timer_d = timer_q;
    winner_d = winner_q;
    pulse_d = 1'b0;
    pos_inc = pos_q[cur_q] + 5'd1;

    if (start) begin
      state_d  = S_WAIT_WHITE;
      cur_d    = '0;
      for (int i = 0; i < 4; i++) pos_d[i] = '0;
      steps_d  = '0;
      color_d  = '0;
      timer_d  = '0;
      winner_d = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        // The die must be removed, leaving an empty white background, before the next roll.
        S_WAIT_WHITE: if (current_state_white) state_d = S_WAIT_ROLL;
        S_WAIT_ROLL: begin
          if (result_ready && stable_color != 2'b00) begin
            case (stable_color)
              2'b01:   steps_d = RED_N;
              2'b10:   steps_d = GREEN_N;
              default: steps_d = BLUE_N;
            endcase
            color_d = stable_color;
            timer_d = RELOAD;
            state_d = S_MOVE;
          end
        end
        S_MOVE: begin
          if (timer_q == '0) begin
            pos_d[cur_q] = pos_inc;
            steps_d      = steps_q - 2'd1;
            timer_d      = RELOAD;
            pulse_d      = 1'b1;
            if (pos_inc == FINISH) begin
              // Landing on the finish square ends the game. Leftover steps are dropped.
              state_d  = S_WIN;
              winner_d = cur_q;
              steps_d  = '0;
            end else if (steps_q == 2'd1) begin
              state_d = S_NEXT;
            end
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_NEXT: begin
          cur_d   = (cur_q == LAST_PL) ? 2'd0 : cur_q + 2'd1;
          state_d = S_WAIT_WHITE;
        end
        S_WIN: ;
        default: state_d = S_IDLE;
      endcase
    end

    done_d = (state_d == S_NEXT);
    win_d  = (state_d == S_WIN);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      for (int i = 0; i < 4; i++) pos_q[i] <= '0;
      steps_q  <= '0;
      color_q  <= '0;
      timer_q  <= '0;
      winner_q <= '0;
      pulse_q  <= 1'b0;
      done_q   <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      pos_q    <= pos_d;
      steps_q  <= steps_d;
      color_q  <= color_d;
      timer_q  <= timer_d;
      winner_q <= winner_d;
      pulse_q  <= pulse_d;
      done_q   <= done_d;
      win_q    <= win_d;
    end
  end

  assign game_state   = state_q;
  assign cur_player   = cur_q;
  assign positions    = {pos_q[3], pos_q[2], pos_q[1], pos_q[0]};
  assign steps_left   = steps_q;
  assign last_color   = color_q;
  assign step_pulse   = pulse_q;
  assign turn_done    = done_q;
  assign winner_valid = win_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_race_turn_controller.sv
// Directed bench for race_turn_controller configured with 2 players, a finish square of 5,
// and STEP_DELAY = 4.
module tb_race_turn_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  stable_color;
  logic        result_ready;
  logic        current_state_white;
  logic        start;
  logic [2:0]  game_state;
  logic [1:0]  cur_player;
  logic [19:0] positions;
  logic [1:0]  steps_left;
  logic [1:0]  last_color;
  logic        step_pulse;
  logic        turn_done;
  logic        winner_valid;
  logic [1:0]  winner;

  int checks = 0;
  int errors = 0;

  race_turn_controller #(
    .NUM_PLAYERS(2), .TRACK_LEN(5), .RED_STEPS(1), .GREEN_STEPS(2),
    .BLUE_STEPS(3), .STEP_DELAY(4)
  ) dut (
    .clk(clk), .reset(reset), .stable_color(stable_color),
    .result_ready(result_ready), .current_state_white(current_state_white),
    .start(start), .game_state(game_state), .cur_player(cur_player),
    .positions(positions), .steps_left(steps_left), .last_color(last_color),
    .step_pulse(step_pulse), .turn_done(turn_done),
    .winner_valid(winner_valid), .winner(winner)
  );

  // Clock
  always #5 clk = ~clk;

  // Sampling and driving both happen 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs n cycles and returns the number of step pulses and turn_done pulses seen.
  task automatic run_count(input int n, output int pulses, output int dones);
    pulses = 0;
    dones  = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (step_pulse) pulses++;
      if (turn_done)  dones++;
    end
  endtask

  // Performs a complete non-winning roll of g steps, starting and ending in WAIT_WHITE.
  task automatic do_roll(input logic [1:0] c, input int g, input string tag);
    int p, d;
    current_state_white = 1'b1;
    tick();
    check({tag, "_wait_roll"}, 32'(game_state), 2);
    stable_color = c;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    stable_color = 2'b00;
    check({tag, "_steps"}, 32'(steps_left), 32'(g));
    run_count(4 * g + 1, p, d);
    current_state_white = 1'b0;
    check({tag, "_pulses"}, 32'(p), 32'(g));
    check({tag, "_turn_done"}, 32'(d), 1);
    check({tag, "_state"}, 32'(game_state), 1);
  endtask

  initial begin
    int p, d;
    reset = 1'b1;
    stable_color = 2'b00;
    result_ready = 1'b0;
    current_state_white = 1'b0;
    start = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_state", 32'(game_state), 0);
    check("rst_pos", 32'(positions), 0);
    check("rst_outs", 32'({cur_player, steps_left, last_color, step_pulse, turn_done, winner_valid, winner}), 0);
    reset = 1'b0;

    // Test 1: start with white background present
    current_state_white = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_state_wait_white", 32'(game_state), 1);
    check("t1_pos", 32'(positions), 0);
    tick();
    check("t1_state_wait_roll", 32'(game_state), 2);
    check("t1_cur", 32'(cur_player), 0);

    // Test 3b: NONE color is ignored in WAIT_ROLL
    result_ready = 1'b1;
    stable_color = 2'b00;
    tick();
    result_ready = 1'b0;
    check("t3_none_ignored", 32'(game_state), 2);

    // Test 2: GREEN roll for player 0
    result_ready = 1'b1;
    stable_color = 2'b10;
    tick();
    result_ready = 1'b0;
    check("t2_move", 32'(game_state), 3);
    check("t2_steps", 32'(steps_left), 2);
    check("t2_color", 32'(last_color), 2);
    // Test 3c: a roll strobe during MOVE changes nothing
    result_ready = 1'b1;
    stable_color = 2'b11;
    tick();
    result_ready = 1'b0;
    stable_color = 2'b00;
    check("t3_move_steps", 32'(steps_left), 2);
    check("t3_move_color", 32'(last_color), 2);
    tick();
    tick();
    check("t2_no_early_pulse", 32'(step_pulse), 0);
    check("t2_no_early_pos", 32'(positions), 0);
    tick();
    check("t2_pulse1", 32'(step_pulse), 1);
    check("t2_pos1", 32'(positions), 1);
    check("t2_steps1", 32'(steps_left), 1);
    tick();
    check("t2_pulse_low", 32'(step_pulse), 0);
    repeat (3) tick();
    check("t2_pulse2", 32'(step_pulse), 1);
    check("t2_pos2", 32'(positions), 2);
    check("t2_next", 32'(game_state), 4);
    check("t2_turn_done", 32'(turn_done), 1);
    check("t2_cur_in_next", 32'(cur_player), 0);
    tick();
    check("t2_wait_white", 32'(game_state), 1);
    check("t2_cur1", 32'(cur_player), 1);
    check("t2_turn_done_low", 32'(turn_done), 0);

    // Test 3a: roll strobe in WAIT_WHITE without white is ignored
    current_state_white = 1'b0;
    result_ready = 1'b1;
    stable_color = 2'b11;
    tick();
    result_ready = 1'b0;
    stable_color = 2'b00;
    check("t3_ww_state", 32'(game_state), 1);
    check("t3_ww_steps", 32'(steps_left), 0);
    check("t3_ww_color", 32'(last_color), 2);

    // Rolls that bring player 0 to square 3; the player index wraps from 1 back to 0
    do_roll(2'b01, 1, "r1_p1_red");
    check("r1_cur_wrap", 32'(cur_player), 0);
    check("r1_pos", 32'(positions), 34);
    do_roll(2'b01, 1, "r2_p0_red");
    check("r2_cur", 32'(cur_player), 1);
    check("r2_pos", 32'(positions), 35);
    do_roll(2'b01, 1, "r3_p1_red");
    check("r3_cur_wrap", 32'(cur_player), 0);
    check("r3_pos", 32'(positions), 67);

    // Test 4: player 0 rolls BLUE from square 3 and wins after 2 steps
    current_state_white = 1'b1;
    tick();
    stable_color = 2'b11;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    stable_color = 2'b00;
    check("t4_steps", 32'(steps_left), 3);
    run_count(8, p, d);
    check("t4_pulses", 32'(p), 2);
    check("t4_pos", 32'(positions), 69);
    check("t4_state", 32'(game_state), 5);
    check("t4_winner_valid", 32'(winner_valid), 1);
    check("t4_winner", 32'(winner), 0);
    check("t4_steps_cleared", 32'(steps_left), 0);
    run_count(12, p, d);
    check("t4_no_third_pulse", 32'(p), 0);
    check("t4_hold", 32'(game_state), 5);

    // Test 5: restart from WIN, then restart in the middle of MOVE
    current_state_white = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_restart_state", 32'(game_state), 1);
    check("t5_restart_pos", 32'(positions), 0);
    check("t5_restart_wv", 32'(winner_valid), 0);
    current_state_white = 1'b1;
    tick();
    stable_color = 2'b10;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    stable_color = 2'b00;
    repeat (5) tick();
    check("t5_mid_pos", 32'(positions), 1);
    current_state_white = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_state", 32'(game_state), 1);
    check("t5_pos", 32'(positions), 0);
    check("t5_cur_steps_color", 32'({cur_player, steps_left, last_color}), 0);
    run_count(12, p, d);
    check("t5_no_pulse", 32'(p), 0);

    // Test 6: asynchronous reset in the middle of MOVE
    current_state_white = 1'b1;
    tick();
    stable_color = 2'b01;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    stable_color = 2'b00;
    tick();
    check("t6_in_move", 32'(game_state), 3);
    reset = 1'b1;
    #1;
    check("t6_async_state", 32'(game_state), 0);
    check("t6_async_outs", 32'({cur_player, positions, steps_left, last_color, step_pulse, turn_done, winner_valid, winner}), 0);
    tick();
    tick();
    reset = 1'b0;
    result_ready = 1'b1;
    stable_color = 2'b11;
    tick();
    result_ready = 1'b0;
    stable_color = 2'b00;
    run_count(12, p, d);
    check("t6_no_pulse", 32'(p), 0);
    check("t6_idle", 32'(game_state), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_resume", 32'(game_state), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/race_turn_controller.md
# race_turn_controller

Game-logic stage directly downstream of the dice color detector. It consumes the detector's stable color, result-ready pulse and white-background level, and runs the turn-based dice race. Each accepted die color moves the current player a fixed number of squares, one step at a time at a visible pace. The block keeps player positions and turn order, declares a winner, and exposes its state for the display/overlay logic.

## Interface
Parameters:
- NUM_PLAYERS, 2: number of players, legal range 2..4.
- TRACK_LEN, 20: finish square, legal range 1..31.
- RED_STEPS, 1: squares moved for a RED die, range 1..3.
- GREEN_STEPS, 2: squares moved for a GREEN die, range 1..3.
- BLUE_STEPS, 3: squares moved for a BLUE die, range 1..3.
- STEP_DELAY, 12_500_000: clock cycles per single-square step; minimum 1.

Ports:
- clk  in  1  system clock (pixel clock domain; one clock only).
- reset  in  1  asynchronous, active-high reset.
- stable_color  in  2  die color from the detector: 00 NONE, 01 RED, 10 GREEN, 11 BLUE.
- result_ready  in  1  one-cycle pulse; stable_color is valid in the same cycle.
- current_state_white  in  1  level; high while an empty white background is detected.
- start  in  1  one-cycle pulse; starts or restarts a game.
- game_state  out  3  0 IDLE, 1 WAIT_WHITE, 2 WAIT_ROLL, 3 MOVE, 4 NEXT, 5 WIN.
- cur_player  out  2  index of the player whose turn it is.
- positions  out  20  player i's position at [5i+4:5i]; unused slots stay 0.
- steps_left  out  2  squares still to move in the current roll.
- last_color  out  2  color of the last accepted roll.
- step_pulse  out  1  one-cycle pulse, coincident with a position increment becoming visible.
- turn_done  out  1  one-cycle pulse, high while in NEXT.
- winner_valid  out  1  level; high in WIN.
- winner  out  2  index of the winning player; meaningful only while winner_valid is high.

## Operation
- Reset: all outputs are 0, game_state is IDLE, and the step timer is 0.
- start from any state, including WIN and MOVE mid-roll:
  - Next cycle: all positions, steps_left, last_color, cur_player and winner_valid are 0.
  - The step timer is cleared and game_state is WAIT_WHITE.
  - start has priority over every other event in the same cycle.
- IDLE: ignores result_ready and current_state_white.
- WAIT_WHITE: waits for current_state_white == 1, then moves to WAIT_ROLL. result_ready in this state is ignored. This guarantees the previous die has been removed before another roll is accepted.
- WAIT_ROLL: on result_ready with stable_color != 00:
  - steps_left is loaded from RED/GREEN/BLUE_STEPS for that color.
  - last_color is set to stable_color.
  - The step timer is loaded with STEP_DELAY-1, and the state moves to MOVE.
  - result_ready with color 00 is ignored.
- MOVE: the timer decrements each cycle. When it reads 0:
  - The current player's position increments by 1 and steps_left decrements.
  - The timer reloads to STEP_DELAY-1, and step_pulse is high the following cycle.
  - After the increment:
    - If the position equals TRACK_LEN, the state goes to WIN and winner is set to cur_player. Any remaining steps are discarded and steps_left is cleared.
    - Otherwise, if steps_left is 0, the state goes to NEXT.
  - result_ready and current_state_white are ignored throughout MOVE.
- NEXT: lasts exactly one cycle. cur_player advances to (cur_player+1) mod NUM_PLAYERS (wraps NUM_PLAYERS-1 -> 0), then the state goes to WAIT_WHITE.
- WIN: holds all outputs until start or reset.
- Positions never exceed TRACK_LEN: a player cannot overshoot because movement is one step at a time.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Input reaction latency is 1 cycle: a qualifying input in cycle N is reflected in game_state at cycle N+1.
- Steps in MOVE:
  - The k-th step (k = 1..3) increments the position on the edge ending the k·STEP_DELAY-th cycle in MOVE.
  - The new position and step_pulse are both visible in the cycle after that edge.
- After the last step: NEXT follows for 1 cycle, then WAIT_WHITE.
- A full G-step roll takes G·STEP_DELAY cycles in MOVE plus 1 cycle in NEXT.
- Async reset mid-MOVE clears all state immediately. No step_pulse is emitted after reset deassertion.

## Test plan
Common configuration: NUM_PLAYERS=2, TRACK_LEN=5, STEP_DELAY=4, default step counts.
1. Reset, pulse start with white=1:
   - Cycle +1: game_state=1.
   - Cycle +2: game_state=2.
   - cur_player=0 and positions=0 throughout.
2. In WAIT_ROLL, result_ready with 10 (GREEN):
   - MOVE, steps_left=2.
   - step_pulse 4 and 8 cycles later.
   - pos0 goes 1 then 2.
   - turn_done once, then cur_player=1 and game_state=1.
3. Ignored inputs:
   - result_ready with 11 while in WAIT_WHITE (white=0): no change.
   - result_ready with 00 in WAIT_ROLL: stays in state 2.
   - result_ready during MOVE: steps_left unaffected.
4. Win on exact arrival: pos0=3, P0 rolls BLUE.
   - After 2 step_pulses, pos0=5, game_state=5, winner_valid=1, winner=0, steps_left=0.
   - No third step_pulse.
5. Wrap and restart:
   - P1 completes a RED roll: cur_player wraps to 0.
   - start pulsed mid-MOVE: positions=0, cur_player=0, game_state=1 next cycle, no further step_pulse.
6. Async reset during MOVE (timer=2): all outputs 0 at once, game_state=0, and start is required to resume.
